// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs one read or write request at a time against a synchronous single-port RAM.
// Define MEM_ACCESS_CTRL_BOUNDS_CHK_EN to reject requests with req_addr >= M (rsp_err=1, no RAM access).
module mem_access_ctrl #(
    parameter int N = 8,
    parameter int M = 32,
    localparam int AddrSz = $clog2(M)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AddrSz-1:0] req_addr,
    input  logic [N-1:0]      req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_rdata,
    output logic              rsp_err,
    output logic [AddrSz-1:0] ram_addr,
    output logic [N-1:0]      ram_w_data,
    output logic              ram_w_en,
    input  logic [N-1:0]      ram_r_data
);

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic [AddrSz-1:0] addr_q;
    logic [N-1:0]      wdata_q;
    logic [N-1:0]      rdata_q;
    logic              accept;
    logic              bad_addr;

    assign accept = req_valid && req_ready;

`ifdef MEM_ACCESS_CTRL_BOUNDS_CHK_EN
    localparam logic [AddrSz:0] Limit = M[AddrSz:0];
    logic err_q;

    assign bad_addr = ({1'b0, req_addr} >= Limit);
    assign rsp_err  = err_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= bad_addr;
        end
    end
`else
    assign bad_addr = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // Rejected addresses never reach addr_q, so the RAM address holds its previous value.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                rdata_q <= '0;
                if (!bad_addr) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
            end else if (state == CAP) begin
                rdata_q <= ram_r_data;
            end
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ram_w_en   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = n_reset;
                if (req_valid && n_reset) begin
                    if (bad_addr) begin
                        next_state = RESP;
                    end else if (req_we) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            WR: begin
                ram_w_en   = 1'b1;
                next_state = RESP;
            end
            RD:  next_state = CAP;
            CAP: next_state = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ram_addr   = addr_q;
    assign ram_w_data = wdata_q;
    assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, corner-case sequences and random traffic
// checked against a simple memory model. Honours MEM_ACCESS_CTRL_BOUNDS_CHK_EN when defined.
module tb_mem_access_ctrl;

    localparam int N = 8;
    localparam int M = 20;
    localparam int AddrSz = $clog2(M);
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHK_EN
    localparam bit BoundsOn = 1'b1;
`else
    localparam bit BoundsOn = 1'b0;
`endif

    logic              clk;
    logic              n_reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AddrSz-1:0] req_addr;
    logic [N-1:0]      req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_rdata;
    logic              rsp_err;
    logic [AddrSz-1:0] ram_addr;
    logic [N-1:0]      ram_w_data;
    logic              ram_w_en;
    logic [N-1:0]      ram_r_data;

    int n_checks = 0;
    int n_fails  = 0;

    mem_access_ctrl #(.N(N), .M(M)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_addr   (ram_addr),
        .ram_w_data (ram_w_data),
        .ram_w_en   (ram_w_en),
        .ram_r_data (ram_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: one-cycle read, no read on a write cycle.
    logic [N-1:0] mem [32];
    logic         mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (ram_w_en) begin
            mem[ram_addr] <= ram_w_data;
        end else begin
            ram_r_data <= mem[ram_addr];
        end
    end

    int           wr_count = 0;
    logic [4:0]   last_wr_addr;
    logic [7:0]   last_wr_data;

    always @(posedge clk) begin
        if (ram_w_en) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= ram_addr;
            last_wr_data <= ram_w_data;
        end
    end

    // Reference memory contents as seen by the core.
    logic [7:0] ref_mem [32];

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelPredict(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                                output logic [7:0] exp_rdata, output logic exp_err, output int exp_lat);
        if (BoundsOn && (int'(addr) >= M)) begin
            exp_rdata = 8'h00;
            exp_err   = 1'b1;
            exp_lat   = 1;
        end else if (we) begin
            ref_mem[addr] = wdata;
            exp_rdata = 8'h00;
            exp_err   = 1'b0;
            exp_lat   = 2;
        end else begin
            exp_rdata = ref_mem[addr];
            exp_err   = 1'b0;
            exp_lat   = 3;
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge after the response handshake.
    task automatic applyStimulus(input string name, input logic we, input logic [4:0] addr,
                                 input logic [7:0] wdata, input int hold, input logic keep,
                                 input logic [7:0] exp_rdata, input logic exp_err, input int exp_lat);
        int         lat;
        int         wr_before;
        logic [4:0] addr_before;
        wr_before   = wr_count;
        addr_before = ram_addr;
        checkOutput({name, " req_ready before"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        if (keep) begin
            req_addr  = addr ^ 5'h01;
            req_wdata = ~wdata;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            checkOutput({name, " req_ready busy"}, req_ready, 0);
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " rdata"}, rsp_rdata, exp_rdata);
        checkOutput({name, " err"}, rsp_err, exp_err);
        if (exp_err) checkOutput({name, " ram_addr held"}, ram_addr, addr_before);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput({name, " hold valid"}, rsp_valid, 1);
            checkOutput({name, " hold rdata"}, rsp_rdata, exp_rdata);
            checkOutput({name, " hold err"}, rsp_err, exp_err);
            checkOutput({name, " hold req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({name, " valid after handshake"}, rsp_valid, 0);
        checkOutput({name, " req_ready after handshake"}, req_ready, 1);
        checkOutput({name, " write pulses"}, wr_count - wr_before, (we && !exp_err) ? 1 : 0);
        if (we && !exp_err) begin
            checkOutput({name, " write addr"}, last_wr_addr, addr);
            checkOutput({name, " write data"}, last_wr_data, wdata);
        end
    endtask

    task automatic modelAndApply(input string name, input logic we, input logic [4:0] addr,
                                 input logic [7:0] wdata, input int hold, input logic keep);
        logic [7:0] e_rdata;
        logic       e_err;
        int         e_lat;
        modelPredict(we, addr, wdata, e_rdata, e_err, e_lat);
        applyStimulus(name, we, addr, wdata, hold, keep, e_rdata, e_err, e_lat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d_rdata;
        logic       d_err;
        int         d_lat;
        int         wr_before;

        vecs[0]  = '{1'b1, 5'd5,  8'hA7, 0, 8'h00, 2};
        vecs[1]  = '{1'b0, 5'd5,  8'h00, 0, 8'hA7, 3};
        vecs[2]  = '{1'b1, 5'd3,  8'h3C, 0, 8'h00, 2};
        vecs[3]  = '{1'b0, 5'd3,  8'h00, 4, 8'h3C, 3};
        vecs[4]  = '{1'b1, 5'd0,  8'h11, 1, 8'h00, 2};
        vecs[5]  = '{1'b1, 5'd19, 8'hFE, 0, 8'h00, 2};
        vecs[6]  = '{1'b0, 5'd0,  8'h00, 0, 8'h11, 3};
        vecs[7]  = '{1'b0, 5'd19, 8'h00, 2, 8'hFE, 3};
        vecs[8]  = '{1'b0, 5'd12, 8'h00, 0, 8'h00, 3};
        vecs[9]  = '{1'b1, 5'd5,  8'h5B, 0, 8'h00, 2};
        vecs[10] = '{1'b0, 5'd5,  8'h00, 0, 8'h5B, 3};

        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        n_reset   = 1'b0;
        mem_clear = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        mem_clear = 1'b0;
        checkOutput("reset req_ready", req_ready, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_err", rsp_err, 0);
        checkOutput("reset ram_w_en", ram_w_en, 0);
        checkOutput("reset rsp_rdata", rsp_rdata, 0);
        checkOutput("reset ram_addr", ram_addr, 0);
        checkOutput("reset ram_w_data", ram_w_data, 0);
        n_reset = 1'b1;
        #1;
        checkOutput("release req_ready", req_ready, 1);
        @(negedge clk);

        $display("[TB] vector table");
        for (int i = 0; i < 11; i++) begin
            modelPredict(vecs[i].we, vecs[i].addr, vecs[i].wdata, d_rdata, d_err, d_lat);
            applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].hold, 1'b0, vecs[i].exp_rdata, 1'b0, vecs[i].exp_lat);
        end

        $display("[TB] request-side stability");
        modelAndApply("stable write", 1'b1, 5'd7, 8'h42, 1, 1'b1);
        modelAndApply("stable read7", 1'b0, 5'd7, 8'h00, 0, 1'b0);
        modelAndApply("stable read6", 1'b0, 5'd6, 8'h00, 0, 1'b0);

        $display("[TB] mid-operation reset");
        modelAndApply("pre-reset write", 1'b1, 5'd9, 8'h5A, 0, 1'b0);
        wr_before = wr_count;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'd9;
        req_wdata = 8'hC3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("midrst w_en in WR", ram_w_en, 1);
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        checkOutput("midrst w_en dropped", ram_w_en, 0);
        checkOutput("midrst rsp_valid", rsp_valid, 0);
        checkOutput("midrst req_ready", req_ready, 0);
        checkOutput("midrst ram_addr", ram_addr, 0);
        repeat (2) @(negedge clk);
        checkOutput("midrst rsp_valid held", rsp_valid, 0);
        n_reset = 1'b1;
        #1;
        checkOutput("midrst req_ready after release", req_ready, 1);
        @(negedge clk);
        checkOutput("midrst no response", rsp_valid, 0);
        checkOutput("midrst no write", wr_count - wr_before, 0);
        checkOutput("midrst mem9", mem[9], 8'h5A);
        modelAndApply("post-reset read9", 1'b0, 5'd9, 8'h00, 0, 1'b0);

        $display("[TB] address bounds");
        modelAndApply("bounds write25", 1'b1, 5'd25, 8'h77, 0, 1'b0);
        modelAndApply("bounds read25", 1'b0, 5'd25, 8'h00, 1, 1'b0);
        modelAndApply("bounds read20", 1'b0, 5'd20, 8'h00, 0, 1'b0);
        modelAndApply("bounds read31", 1'b0, 5'd31, 8'h00, 0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            modelAndApply($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          8'($urandom), $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
